hdb3_polarity: RTL and testbench
================================

# hdb3_polarity

Final stage of the HDB3 encoder chain. It sits directly downstream of the B-insertion stage and consumes that stage's 2-bit symbol stream (zero / mark / V / B). It assigns alternate-mark polarity with HDB3 violation rules and drives registered positive/negative line rails. It also checks V-pulse alternation as an integrity monitor of the upstream stages.

## Interface
Parameters:
- DSUM_W, 4: width of the signed running digital-sum register (only meaningful with HDB3_DC_MONITOR_EN).
- DSUM_LIMIT, 3: magnitude above which the digital sum is flagged.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset. Keeps the codebase `reset` base name without `_n`, since polarity is fixed high.
- bit_en  input  1  bit-period strobe; state advances only on cycles with bit_en=1.
- data_addB  input  2  symbol from the B-insertion stage: 2'b00 zero, 2'b01 mark, 2'b10 V, 2'b11 B.
- hdb3_pos  output  1  positive rail; 1 = +pulse this bit period.
- hdb3_neg  output  1  negative rail; 1 = −pulse this bit period.
- v_err  output  1  one-bit-period pulse: a V has the same polarity as the previous V.
- dsum  output  DSUM_W  signed running digital sum (two's complement).
- dc_err  output  1  sticky: |dsum| exceeded DSUM_LIMIT.

## Operation
- State:
  - last_pol: polarity of the last nonzero pulse. 0 = +, 1 = −. Reset value 1, so the first mark after reset is +.
  - last_v_pol: polarity of the last V.
  - v_seen: a V has occurred since reset. Reset value 0.
- On bit_en=1, per symbol:
  - 00: pos=0, neg=0; last_pol unchanged.
  - 01 (mark): polarity = ~last_pol; last_pol ← polarity.
  - 11 (B): same as a mark; polarity = ~last_pol; last_pol ← polarity.
  - 10 (V): polarity = last_pol (deliberate violation); last_pol unchanged.
- V check, on every V:
  - If v_seen=1 and polarity == last_v_pol, then v_err=1 for that bit period.
  - Every V sets last_v_pol ← polarity and v_seen ← 1.
- Rails: exactly one of hdb3_pos/hdb3_neg is 1 for nonzero symbols; both are 0 for zero. The two rails are never both 1.
- Reset values: hdb3_pos=0, hdb3_neg=0, v_err=0, dsum=0, dc_err=0.
- Reset asserted mid-stream clears all state on that clock edge regardless of bit_en. The first symbol after reset is treated as the start of a new stream.

## Timing
- Latency: the symbol sampled at a clk edge with bit_en=1 appears on the rails after that same edge (1 clk, registered outputs).
- bit_en=0: all outputs and state hold their values. The rails hold the current bit for the full bit period.
- v_err is asserted together with the rails of the offending V. It clears at the next bit_en=1 edge.
- bit_en may be tied to 1, giving one symbol per clk.
- There is no back-pressure; the upstream stage must present a valid symbol on every bit_en cycle.

## Configuration
- HDB3_DC_MONITOR_EN defined:
  - dsum adds +1 on each + pulse and −1 on each − pulse, updated with the rails.
  - dsum saturates at the DSUM_W signed limits and never wraps.
  - dc_err sets when |dsum| > DSUM_LIMIT and stays set until reset.
- Not defined: dsum and dc_err are constant 0, and no sum logic is synthesized.

## Structure
- Shared package hdb3_pkg, used by every stage of the encoder chain:
  - symbol constants CODE_ZERO, CODE_ONE, CODE_V, CODE_B;
  - polarity constants POL_POS, POL_NEG.
- Sub-module hdb3_dsum_mon: saturating signed accumulator plus threshold/sticky flag. It is instantiated only under HDB3_DC_MONITOR_EN.

## Test plan
- Reset, then symbols 01,01,00,00,00,10 with bit_en=1 → rails +,−,0,0,0,− ; v_err=0.
- Continue with 11,00,00,10 → rails +,0,0,+. The V polarities so far are −,+ (alternating), so v_err stays 0.
- Inject 01,00,00,00,10 immediately after the previous V → the mark is −, the V is −, which equals the last V's −? No: the last V was +, so v_err=0. Then inject 10 alone → the V repeats polarity −, so v_err=1 for exactly one bit period.
- bit_en toggling 1,0,0,1 with symbols 01,xx,xx,01 → rails hold + for three cycles, then −. Ignored symbols change no state.
- Reset asserted between two marks → the next mark is + regardless of the pre-reset polarity; v_seen is cleared, so the next V raises no v_err.
- With HDB3_DC_MONITOR_EN, DSUM_LIMIT=1, force symbols 10,10 after a + mark → dsum 1,2,3 and dc_err sticks at 1 through later balanced traffic until reset. Without the macro, dsum=0 and dc_err=0 throughout.

Source files
------------

// File: rtl/hdb3_pkg.sv
// Shared HDB3 encoder-chain definitions: symbol codes emitted by the B-insertion
// stage and the line-polarity encoding used for the last-pulse state.
package hdb3_pkg;

    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_ONE  = 2'b01;
    localparam logic [1:0] CODE_V    = 2'b10;
    localparam logic [1:0] CODE_B    = 2'b11;

    localparam logic POL_POS = 1'b0;
    localparam logic POL_NEG = 1'b1;

endpackage

// File: rtl/hdb3_dsum_mon.sv
// Saturating signed running digital sum of the line pulses, with a sticky flag
// raised once the magnitude exceeds DSUM_LIMIT. Only built under HDB3_DC_MONITOR_EN.
module hdb3_dsum_mon #(
    parameter int DSUM_W     = 4,
    parameter int DSUM_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     pulse_pos,
    input  logic                     pulse_neg,
    output logic signed [DSUM_W-1:0] dsum,
    output logic                     dc_err
);

    localparam logic signed [DSUM_W-1:0] DSUM_MAX = {1'b0, {(DSUM_W-1){1'b1}}};
    localparam logic signed [DSUM_W-1:0] DSUM_MIN = {1'b1, {(DSUM_W-1){1'b0}}};

    logic signed [DSUM_W-1:0] dsum_q, dsum_d;
    logic                     dc_err_q, dc_err_d;

    always_comb begin
        dsum_d   = dsum_q;
        dc_err_d = dc_err_q;
        if (en) begin
            if (pulse_pos && (dsum_q != DSUM_MAX)) begin
                dsum_d = dsum_q + DSUM_W'(1);
            end else if (pulse_neg && (dsum_q != DSUM_MIN)) begin
                dsum_d = dsum_q - DSUM_W'(1);
            end
            // Flag on the sum that goes out with this bit, so the flag and dsum agree.
            if ((int'(dsum_d) > DSUM_LIMIT) || (int'(dsum_d) < -DSUM_LIMIT)) begin
                dc_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dsum_q   <= '0;
            dc_err_q <= 1'b0;
        end else begin
            dsum_q   <= dsum_d;
            dc_err_q <= dc_err_d;
        end
    end

    assign dsum   = dsum_q;
    assign dc_err = dc_err_q;

endmodule

// File: rtl/hdb3_polarity.sv
// HDB3 output stage: AMI polarity with V violations, registered line rails and a
// V-alternation integrity check. HDB3_DC_MONITOR_EN adds the running digital-sum monitor.
module hdb3_polarity
    import hdb3_pkg::*;
#(
    parameter int DSUM_W     = 4,
    parameter int DSUM_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bit_en,
    input  logic [1:0]               data_addB,
    output logic                     hdb3_pos,
    output logic                     hdb3_neg,
    output logic                     v_err,
    output logic signed [DSUM_W-1:0] dsum,
    output logic                     dc_err
);

    logic pos_q, pos_d;
    logic neg_q, neg_d;
    logic v_err_q, v_err_d;
    logic last_pol_q, last_pol_d;
    logic last_v_pol_q, last_v_pol_d;
    logic v_seen_q, v_seen_d;
    logic pol;

    always_comb begin
        pos_d        = pos_q;
        neg_d        = neg_q;
        v_err_d      = v_err_q;
        last_pol_d   = last_pol_q;
        last_v_pol_d = last_v_pol_q;
        v_seen_d     = v_seen_q;
        pol          = last_pol_q;
        if (bit_en) begin
            pos_d   = 1'b0;
            neg_d   = 1'b0;
            v_err_d = 1'b0;
            case (data_addB)
                CODE_ONE, CODE_B: begin
                    pol        = ~last_pol_q;
                    last_pol_d = pol;
                    pos_d      = (pol == POL_POS);
                    neg_d      = (pol == POL_NEG);
                end
                CODE_V: begin
                    // A V repeats the last pulse polarity and does not move last_pol.
                    pol          = last_pol_q;
                    pos_d        = (pol == POL_POS);
                    neg_d        = (pol == POL_NEG);
                    v_err_d      = v_seen_q && (pol == last_v_pol_q);
                    last_v_pol_d = pol;
                    v_seen_d     = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q        <= 1'b0;
            neg_q        <= 1'b0;
            v_err_q      <= 1'b0;
            last_pol_q   <= POL_NEG;
            last_v_pol_q <= POL_POS;
            v_seen_q     <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            neg_q        <= neg_d;
            v_err_q      <= v_err_d;
            last_pol_q   <= last_pol_d;
            last_v_pol_q <= last_v_pol_d;
            v_seen_q     <= v_seen_d;
        end
    end

    assign hdb3_pos = pos_q;
    assign hdb3_neg = neg_q;
    assign v_err    = v_err_q;

    if ((DSUM_W < 2) || (DSUM_LIMIT < 0)) begin : g_bad_dsum_cfg
        $error("hdb3_polarity: DSUM_W must be >= 2 and DSUM_LIMIT >= 0");
    end

`ifdef HDB3_DC_MONITOR_EN
    hdb3_dsum_mon #(
        .DSUM_W     (DSUM_W),
        .DSUM_LIMIT (DSUM_LIMIT)
    ) u_dsum_mon (
        .clk       (clk),
        .reset     (reset),
        .en        (bit_en),
        .pulse_pos (pos_d),
        .pulse_neg (neg_d),
        .dsum      (dsum),
        .dc_err    (dc_err)
    );
`else
    assign dsum   = '0;
    assign dc_err = 1'b0;
`endif

endmodule

// File: tb/tb_hdb3_polarity.sv
// Scoreboard bench for hdb3_polarity: directed HDB3 sequences plus random traffic
// checked against a pulse-level model (+1/-1 polarities, integer digital sum).
module tb_hdb3_polarity;

    localparam int DSUM_W     = 4;
    localparam int DSUM_LIMIT = 1;
    localparam int SUM_MAX    = (1 << (DSUM_W - 1)) - 1;
    localparam int SUM_MIN    = -(1 << (DSUM_W - 1));

    typedef struct {
        bit pos;
        bit neg;
        bit verr;
        int dsum;
        bit dcerr;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     bit_en;
    logic [1:0]               data_addB;
    logic                     hdb3_pos;
    logic                     hdb3_neg;
    logic                     v_err;
    logic signed [DSUM_W-1:0] dsum;
    logic                     dc_err;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    // Model state: polarity as +1/-1, last V polarity (0 = no V since reset)
    int m_last;
    int m_last_v;
    int m_dsum;
    bit m_dcerr;
    bit m_pos, m_neg, m_verr;

    hdb3_polarity #(
        .DSUM_W     (DSUM_W),
        .DSUM_LIMIT (DSUM_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_en    (bit_en),
        .data_addB (data_addB),
        .hdb3_pos  (hdb3_pos),
        .hdb3_neg  (hdb3_neg),
        .v_err     (v_err),
        .dsum      (dsum),
        .dc_err    (dc_err)
    );

    always #5 clk = ~clk;

    function automatic void modelStep(input bit rst, input bit en, input bit [1:0] sym);
        int p;
        if (rst) begin
            m_last   = -1;
            m_last_v = 0;
            m_dsum   = 0;
            m_dcerr  = 1'b0;
            m_pos    = 1'b0;
            m_neg    = 1'b0;
            m_verr   = 1'b0;
        end else if (en) begin
            p      = 0;
            m_verr = 1'b0;
            if (sym == 2'b01 || sym == 2'b11) begin
                p      = -m_last;
                m_last = p;
            end else if (sym == 2'b10) begin
                p        = m_last;
                m_verr   = (m_last_v == p);
                m_last_v = p;
            end
            m_pos = (p > 0);
            m_neg = (p < 0);
`ifdef HDB3_DC_MONITOR_EN
            m_dsum = m_dsum + p;
            if (m_dsum > SUM_MAX) m_dsum = SUM_MAX;
            if (m_dsum < SUM_MIN) m_dsum = SUM_MIN;
            if (m_dsum > DSUM_LIMIT || m_dsum < -DSUM_LIMIT) m_dcerr = 1'b1;
`endif
        end
    endfunction

    // Drive one clock of stimulus and queue the outputs expected after that edge.
    task automatic applyStimulus(input bit rst, input bit en, input bit [1:0] sym);
        exp_t e;
        reset     = rst;
        bit_en    = en;
        data_addB = sym;
        modelStep(rst, en, sym);
        e.pos   = m_pos;
        e.neg   = m_neg;
        e.verr  = m_verr;
        e.dsum  = m_dsum;
        e.dcerr = m_dcerr;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic checkBit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkBit("hdb3_pos", int'(hdb3_pos), int'(e.pos));
        checkBit("hdb3_neg", int'(hdb3_neg), int'(e.neg));
        checkBit("v_err", int'(v_err), int'(e.verr));
        checkBit("dsum", int'(dsum), e.dsum);
        checkBit("dc_err", int'(dc_err), int'(e.dcerr));
    endtask

    // Monitor: every clock the DUT presents a new (or held) bit; compare against the queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit [1:0] dir_syms[];
        bit [1:0] sym;
        bit       en;
        bit       rst;

        applyStimulus(1'b1, 1'b0, 2'b00);
        applyStimulus(1'b1, 1'b1, 2'b01);

        // Mark/V sequence ending with a V that repeats the previous V polarity
        dir_syms = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10,
                     2'b11, 2'b00, 2'b00, 2'b10,
                     2'b01, 2'b00, 2'b00, 2'b00, 2'b10,
                     2'b10};
        foreach (dir_syms[i]) applyStimulus(1'b0, 1'b1, dir_syms[i]);

        // bit_en gating: ignored symbols must not move state
        applyStimulus(1'b1, 1'b0, 2'b00);
        applyStimulus(1'b0, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b0, 2'b10);
        applyStimulus(1'b0, 1'b0, 2'b11);
        applyStimulus(1'b0, 1'b1, 2'b01);

        // Reset between marks, then a V that must not raise v_err
        applyStimulus(1'b0, 1'b1, 2'b01);
        applyStimulus(1'b1, 1'b0, 2'b01);
        applyStimulus(1'b0, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b1, 2'b10);
        applyStimulus(1'b0, 1'b1, 2'b10);

        // Positive and negative saturation of the digital sum
        applyStimulus(1'b1, 1'b1, 2'b00);
        applyStimulus(1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 2'b10);
        applyStimulus(1'b0, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b1, 2'b11);
        applyStimulus(1'b1, 1'b1, 2'b00);
        applyStimulus(1'b0, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 2'b10);

        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(99) == 0);
            en  = ($urandom_range(9) < 7);
            sym = 2'($urandom_range(3));
            applyStimulus(rst, en, sym);
        end

        bit_en = 1'b0;
        reset  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkBit("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
